// File: rtl/rv_core_pkg.sv
// Shared definitions for the RISC-V core front end: fetch FSM states,
// datapath width and instruction alignment helpers.
package rv_core_pkg;

    localparam int XLEN = 32;
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;
    localparam logic [XLEN-1:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] & INSTR_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC priority mux: trap > redirect > sequential PC+4.
// A misaligned redirect target is replaced by the trap vector and flagged.
module next_pc_select
    import rv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic [XLEN-1:0] i_PC,
    input  logic            i_Trap,
    input  logic            i_Redirect,
    input  logic [XLEN-1:0] i_RedirectTarget,
    output logic [XLEN-1:0] o_NextPC,
    output logic            o_Event,
    output logic            o_Misalign
);

    logic target_bad;

    assign target_bad = is_misaligned(i_RedirectTarget);

    always_comb begin
        o_NextPC   = i_PC + PC_INCR;
        o_Event    = i_Trap | i_Redirect;
        o_Misalign = 1'b0;
        if (i_Trap) begin
            o_NextPC = TRAP_VECTOR;
        end else if (i_Redirect) begin
            o_NextPC   = target_bad ? TRAP_VECTOR : i_RedirectTarget;
            o_Misalign = target_bad;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch FSM: drives the PC register enable/next value, runs the req/ack
// instruction-memory port and hands fetched words to decode via valid/ready.
module fetch_sequencer
    import rv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic [XLEN-1:0] i_PC,
    output logic            o_PC_EN,
    output logic [XLEN-1:0] o_NewPC,
    output logic            o_IMemReq,
    output logic [XLEN-1:0] o_IMemAddr,
    input  logic            i_IMemAck,
    input  logic [XLEN-1:0] i_IMemData,
    output logic [XLEN-1:0] o_Instr,
    output logic            o_InstrValid,
    input  logic            i_InstrReady,
    input  logic            i_Redirect,
    input  logic [XLEN-1:0] i_RedirectTarget,
    input  logic            i_Trap,
    output logic            o_MisalignErr,
    output logic [XLEN-1:0] o_FetchCount
);

    fetch_state_t    state_reg, state_next;
    logic            pend_valid_reg;
    logic [XLEN-1:0] pend_target_reg;
    logic            req_reg;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] instr_reg;
    logic            valid_reg;
    logic            misalign_reg;
    logic [XLEN-1:0] count_reg;

    logic            sel_event, sel_misalign;
    logic [XLEN-1:0] sel_pc;
    logic            pc_en_next;
    logic [XLEN-1:0] new_pc_next;
    logic            capture_next, accept_next;

    next_pc_select #(
        .TRAP_VECTOR(TRAP_VECTOR)
    ) u_next_pc_select (
        .i_PC            (i_PC),
        .i_Trap          (i_Trap),
        .i_Redirect      (i_Redirect),
        .i_RedirectTarget(i_RedirectTarget),
        .o_NextPC        (sel_pc),
        .o_Event         (sel_event),
        .o_Misalign      (sel_misalign)
    );

    always_comb begin
        state_next   = state_reg;
        pc_en_next   = 1'b0;
        new_pc_next  = '0;
        capture_next = 1'b0;
        accept_next  = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                pc_en_next  = 1'b1;
                new_pc_next = RESET_VECTOR;
                state_next  = ST_REQ;
            end
            ST_REQ: begin
                // A redirect seen during this fetch (now or earlier) kills the returned word.
                if (i_IMemAck) begin
                    if (sel_event) begin
                        pc_en_next  = 1'b1;
                        new_pc_next = sel_pc;
                    end else if (pend_valid_reg) begin
                        pc_en_next  = 1'b1;
                        new_pc_next = pend_target_reg;
                    end else begin
                        capture_next = 1'b1;
                        state_next   = ST_VALID;
                    end
                end
            end
            ST_VALID: begin
                accept_next = i_InstrReady;
                if (sel_event || i_InstrReady) begin
                    pc_en_next  = 1'b1;
                    new_pc_next = sel_pc;
                    state_next  = ST_REQ;
                end
            end
            default: state_next = ST_BOOT;
        endcase
        if (i_Rst) begin
            pc_en_next  = 1'b0;
            new_pc_next = '0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg       <= ST_BOOT;
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= '0;
            req_reg         <= 1'b0;
            addr_reg        <= '0;
            instr_reg       <= '0;
            valid_reg       <= 1'b0;
            misalign_reg    <= 1'b0;
            count_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= (state_next == ST_REQ);
            // Address follows the PC value that will be present once the request is up.
            addr_reg     <= (state_next == ST_REQ) ? (pc_en_next ? new_pc_next : i_PC) : '0;
            misalign_reg <= sel_misalign && (state_reg != ST_BOOT);

            if (state_reg == ST_REQ && !i_IMemAck && sel_event) begin
                pend_valid_reg  <= 1'b1;
                pend_target_reg <= sel_pc;
            end else if (state_reg != ST_REQ || i_IMemAck) begin
                pend_valid_reg  <= 1'b0;
            end

            if (capture_next) begin
                instr_reg <= i_IMemData;
                valid_reg <= 1'b1;
            end else if (state_reg == ST_VALID && state_next == ST_REQ) begin
                valid_reg <= 1'b0;
            end

            if (accept_next) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign o_PC_EN       = pc_en_next;
    assign o_NewPC       = new_pc_next;
    assign o_IMemReq     = req_reg;
    assign o_IMemAddr    = addr_reg;
    assign o_Instr       = instr_reg;
    assign o_InstrValid  = valid_reg;
    assign o_MisalignErr = misalign_reg;
    assign o_FetchCount  = count_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// fetch/redirect run scored against an address/count reference model.
module tb_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'hDEAD_BEE0;
    logic        pc_en;
    logic [31:0] new_pc;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0;
    logic [31:0] data = '0;
    logic [31:0] instr;
    logic        valid;
    logic        ready = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] tgt = '0;
    logic        trap = 1'b0;
    logic        mis;
    logic [31:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    fetch_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_PC(pc), .o_PC_EN(pc_en), .o_NewPC(new_pc),
        .o_IMemReq(req), .o_IMemAddr(addr), .i_IMemAck(ack), .i_IMemData(data),
        .o_Instr(instr), .o_InstrValid(valid), .i_InstrReady(ready),
        .i_Redirect(redir), .i_RedirectTarget(tgt), .i_Trap(trap),
        .o_MisalignErr(mis), .o_FetchCount(cnt)
    );

    always #5 clk = ~clk;

    // The PC register the sequencer controls.
    always @(posedge clk) if (pc_en) pc <= new_pc;

    function automatic logic [31:0] resolve(input bit t, input logic [31:0] target);
        if (t) return TV;
        return (target[1:0] != 2'b00) ? TV : target;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!req && n < 20) begin
            tick();
            n++;
        end
        ok = req;
    endtask

    task automatic fetch_to_valid(input logic [31:0] word);
        bit ok;
        wait_req(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL req_timeout: req=%0b required 1", req);
        end
        ack = 1'b1; data = word;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({pc_en, new_pc, req, addr, instr, valid, mis, cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: pc_en=%0b new_pc=%h req=%0b addr=%h instr=%h valid=%0b mis=%0b cnt=%0d required all 0",
                     pc_en, new_pc, req, addr, instr, valid, mis, cnt);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || new_pc !== RV) begin
            n_fail++;
            $display("FAIL boot_pc: pc_en=%0b new_pc=%h required 1/%h", pc_en, new_pc, RV);
        end
        tick();
        n_checks++;
        if (req !== 1'b1 || addr !== RV || pc !== RV) begin
            n_fail++;
            $display("FAIL first_req: req=%0b addr=%h pc=%h required 1/%h/%h", req, addr, pc, RV, RV);
        end
        exp_cnt = 0;
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        bit ok;
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_req(ok);
            n_checks++;
            if (!ok || addr !== RV + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL seq_addr%0d: req=%0b addr=%h required 1/%h", k, req, addr, RV + 32'(4 * k));
            end
            tick();
            ack = 1'b1; data = 32'h0000_0013;
            tick();
            ack = 1'b0;
            n_checks++;
            if (valid !== 1'b1 || instr !== 32'h0000_0013) begin
                n_fail++;
                $display("FAIL seq_instr%0d: valid=%0b instr=%h required 1/00000013", k, valid, instr);
            end
            tick();
            exp_cnt++;
            n_checks++;
            if (cnt !== 32'(exp_cnt) || valid !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_count%0d: cnt=%0d valid=%0b required %0d/0", k, cnt, valid, exp_cnt);
            end
            $display("seq fetch %0d addr=%h cnt=%0d", k, RV + 32'(4 * k), cnt);
        end
        ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] pc0, i0;
        fetch_to_valid(32'h1234_5678);
        pc0 = pc;
        i0  = instr;
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (valid !== 1'b1 || instr !== 32'h1234_5678 || pc !== pc0 || req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d: valid=%0b instr=%h pc=%h req=%0b required 1/12345678/%h/0",
                         s, valid, instr, pc, req, pc0);
            end
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        exp_cnt++;
        n_checks++;
        if (pc !== pc0 + 32'd4 || req !== 1'b1 || cnt !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL stall_accept: pc=%h req=%0b cnt=%0d required %h/1/%0d", pc, req, cnt, pc0 + 32'd4, exp_cnt);
        end
        $display("stall accept pc=%h instr=%h", pc, i0);
    endtask

    task automatic test_redirect_valid();
        fetch_to_valid(32'hCAFE_0001);
        redir = 1'b1; tgt = 32'h0000_0200;
        tick();
        redir = 1'b0;
        n_checks++;
        if (pc !== 32'h200 || valid !== 1'b0 || addr !== 32'h200 || req !== 1'b1 || cnt !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL redirect_valid: pc=%h valid=%0b addr=%h req=%0b cnt=%0d required 200/0/200/1/%0d",
                     pc, valid, addr, req, cnt, exp_cnt);
        end
        $display("redirect in VALID pc=%h", pc);
    endtask

    task automatic test_pending();
        redir = 1'b1; tgt = 32'h0000_0300;
        tick();
        redir = 1'b0;
        repeat (2) tick();
        ack = 1'b1; data = 32'hBAD0_BAD0;
        tick();
        ack = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || pc !== 32'h300 || addr !== 32'h300 || req !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_redirect: valid=%0b pc=%h addr=%h req=%0b required 0/300/300/1", valid, pc, addr, req);
        end
        $display("pending redirect addr=%h", addr);
    endtask

    task automatic test_trap_priority();
        fetch_to_valid(32'h0000_0033);
        trap = 1'b1; redir = 1'b1; tgt = 32'h0000_0400;
        tick();
        trap = 1'b0; redir = 1'b0;
        n_checks++;
        if (pc !== TV || mis !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_priority: pc=%h mis=%0b valid=%0b required %h/0/0", pc, mis, valid, TV);
        end
        fetch_to_valid(32'h0000_0033);
        redir = 1'b1; tgt = 32'h0000_0402;
        tick();
        redir = 1'b0;
        n_checks++;
        if (pc !== TV || mis !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_redirect: pc=%h mis=%0b required %h/1", pc, mis, TV);
        end
        tick();
        n_checks++;
        if (mis !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_pulse: mis=%0b required 0", mis);
        end
        $display("trap/misalign pc=%h", pc);
    endtask

    task automatic test_wrap();
        fetch_to_valid(32'h0000_0013);
        redir = 1'b1; tgt = 32'hFFFF_FFFC;
        tick();
        redir = 1'b0;
        n_checks++;
        if (addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_addr: addr=%h required fffffffc", addr);
        end
        fetch_to_valid(32'h0000_0013);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        exp_cnt++;
        n_checks++;
        if (pc !== 32'h0 || addr !== 32'h0 || cnt !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL wrap_pc: pc=%h addr=%h cnt=%0d required 0/0/%0d", pc, addr, cnt, exp_cnt);
        end
        $display("wrap pc=%h", pc);
    endtask

    task automatic test_reset_midfetch();
        bit ok;
        redir = 1'b1; tgt = 32'h0000_0500;
        tick();
        redir = 1'b0;
        wait_req(ok);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ack = 1'b1; data = 32'hFFFF_0000;
        #1;
        n_checks++;
        if ({req, addr, instr, valid, mis, cnt} !== '0 || pc_en !== 1'b1 || new_pc !== RV) begin
            n_fail++;
            $display("FAIL reset_midfetch: req=%0b addr=%h instr=%h valid=%0b mis=%0b cnt=%0d pc_en=%0b new_pc=%h required zeros, boot to %h",
                     req, addr, instr, valid, mis, cnt, pc_en, new_pc, RV);
        end
        tick();
        ack = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || req !== 1'b1 || addr !== RV || pc !== RV || cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL boot_ack_ignored: valid=%0b req=%0b addr=%h pc=%h cnt=%0d required 0/1/%h/%h/0",
                     valid, req, addr, pc, cnt, RV, RV);
        end
        exp_cnt = 0;
        $display("reset mid-fetch reload pc=%h", pc);
    endtask

    task automatic test_random();
        logic [31:0] exp_addr = RV;
        bit ok;
        for (int t = 0; t < 40; t++) begin
            int d, evc, stall;
            bit ev, ev_trap, exp_mis, vev, vtrap, vready;
            logic [31:0] word, ev_tgt, pend;
            wait_req(ok);
            n_checks++;
            if (!ok || addr !== exp_addr) begin
                n_fail++;
                $display("FAIL rnd_addr%0d: req=%0b addr=%h required 1/%h", t, req, addr, exp_addr);
            end
            d = $urandom_range(0, 3);
            ev = ($urandom_range(0, 3) == 0);
            evc = $urandom_range(0, d);
            word = $urandom;
            pend = exp_addr;
            for (int c = 0; c <= d; c++) begin
                ack = (c == d);
                data = word;
                if (ev && c == evc) begin
                    ev_trap = ($urandom_range(0, 3) == 0);
                    ev_tgt = {$urandom, 2'b00} | 32'($urandom_range(0, 3) == 0);
                    trap = ev_trap; redir = !ev_trap || $urandom_range(0, 1) == 1; tgt = ev_tgt;
                    pend = resolve(ev_trap, ev_tgt);
                    exp_mis = !ev_trap && (ev_tgt[1:0] != 2'b00);
                end
                tick();
                ack = 1'b0; trap = 1'b0; redir = 1'b0;
                if (ev && c == evc) begin
                    n_checks++;
                    if (mis !== exp_mis) begin
                        n_fail++;
                        $display("FAIL rnd_req_mis%0d: mis=%0b required %0b", t, mis, exp_mis);
                    end
                end
            end
            if (ev) begin
                exp_addr = pend;
                n_checks++;
                if (valid !== 1'b0 || pc !== exp_addr) begin
                    n_fail++;
                    $display("FAIL rnd_discard%0d: valid=%0b pc=%h required 0/%h", t, valid, pc, exp_addr);
                end
                $display("rnd %0d fetch killed, redirect to %h", t, exp_addr);
                continue;
            end
            n_checks++;
            if (valid !== 1'b1 || instr !== word) begin
                n_fail++;
                $display("FAIL rnd_instr%0d: valid=%0b instr=%h required 1/%h", t, valid, instr, word);
            end
            stall = $urandom_range(0, 3);
            repeat (stall) tick();
            vev = ($urandom_range(0, 2) == 0);
            vtrap = vev && ($urandom_range(0, 2) == 0);
            vready = !vev || ($urandom_range(0, 1) == 1);
            ev_tgt = {$urandom, 2'b00} | 32'($urandom_range(0, 3) == 0);
            trap = vtrap; redir = vev && !vtrap; tgt = ev_tgt; ready = vready;
            tick();
            trap = 1'b0; redir = 1'b0; ready = 1'b0;
            if (vready) exp_cnt++;
            exp_addr = vev ? resolve(vtrap, ev_tgt) : exp_addr + 32'd4;
            exp_mis = vev && !vtrap && (ev_tgt[1:0] != 2'b00);
            n_checks++;
            if (cnt !== 32'(exp_cnt) || valid !== 1'b0 || pc !== exp_addr || mis !== exp_mis) begin
                n_fail++;
                $display("FAIL rnd_exit%0d: cnt=%0d valid=%0b pc=%h mis=%0b required %0d/0/%h/%0b",
                         t, cnt, valid, pc, mis, exp_cnt, exp_addr, exp_mis);
            end
            $display("rnd %0d instr=%h stall=%0d ready=%0b event=%0b next=%h cnt=%0d",
                     t, word, stall, vready, vev, exp_addr, cnt);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_valid();
        test_pending();
        test_trap_priority();
        test_wrap();
        test_reset_midfetch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the program counter register and the instruction-memory fetch port for the RISC-V core. Each cycle it decides whether to enable the PC register and which next-PC value to drive. The next PC is one of: reset vector, sequential PC+4, branch/jump target, or trap vector. It runs a request/acknowledge fetch to instruction memory and presents fetched instructions to decode with a valid/ready handshake.

Parameters:
RESET_VECTOR, 32'h0000_0000, first PC loaded after reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect

Ports:
i_Clk  in  1  system clock; all state changes on rising edge
i_Rst  in  1  synchronous, active-high reset
i_PC  in  32  current value from the program counter register
o_PC_EN  out  1  PC register load enable (PC updates at the next edge)
o_NewPC  out  32  value loaded into the PC register when o_PC_EN=1
o_IMemReq  out  1  instruction fetch request, level, held until ack
o_IMemAddr  out  32  fetch address (equals i_PC while o_IMemReq=1)
i_IMemAck  in  1  single-cycle acknowledge; i_IMemData valid in the same cycle
i_IMemData  in  32  fetched instruction word
o_Instr  out  32  registered instruction to decode
o_InstrValid  out  1  o_Instr valid
i_InstrReady  in  1  decode accepts o_Instr this cycle
i_Redirect  in  1  branch/jump taken (single-cycle pulse)
i_RedirectTarget  in  32  branch/jump target
i_Trap  in  1  trap request (single-cycle pulse)
o_MisalignErr  out  1  one-cycle pulse: redirect target had [1:0]!=0
o_FetchCount  out  32  count of instructions accepted by decode, wraps

Behaviour:
- Reset (i_Rst=1 at edge):
  - state=BOOT
  - o_PC_EN=0, o_NewPC=0, o_IMemReq=0, o_IMemAddr=0
  - o_Instr=0, o_InstrValid=0, o_MisalignErr=0, o_FetchCount=0
  - pending-redirect flag cleared
- Reset mid-fetch: an outstanding fetch is abandoned; an ack arriving while in BOOT is ignored.
- o_PC_EN and o_NewPC are combinational from state and inputs. All other outputs are registered.
- FSM states:
  - BOOT: o_PC_EN=1, o_NewPC=RESET_VECTOR; next state REQ.
  - REQ: o_IMemReq=1, o_IMemAddr=i_PC.
    - On i_IMemAck with no pending redirect: o_Instr<=i_IMemData, o_InstrValid<=1; next state VALID.
    - On i_IMemAck with a pending redirect: data discarded; PC loads the pending target; next state REQ (fresh request the following cycle).
  - VALID: o_InstrValid=1.
    - If i_InstrReady and no redirect/trap: o_PC_EN=1, o_NewPC=i_PC+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0). o_FetchCount+=1, o_InstrValid<=0; next state REQ.
    - If i_InstrReady=0: o_Instr and o_InstrValid hold, PC holds.
- Redirect priority: i_Trap > i_Redirect > sequential.
  - Trap target is TRAP_VECTOR.
  - Redirect target is i_RedirectTarget. If i_RedirectTarget[1:0]!=0, the target is replaced by TRAP_VECTOR and o_MisalignErr pulses for one cycle.
- Redirect/trap in VALID (with or without ready):
  - o_PC_EN=1, o_NewPC=resolved target, o_InstrValid<=0; next state REQ.
  - If ready was also high, o_FetchCount still increments (the instruction was consumed).
- Redirect/trap in REQ without ack: the resolved target is latched into a pending register. A later event in the same fetch overwrites it, with trap priority applied.
- Redirect/trap in REQ in the same cycle as ack: treated as pending-at-ack (data discarded, PC=target).
- Redirect/trap in BOOT: ignored.
- No PC update occurs in REQ except at the ack-with-pending cycle.
- Latency:
  - Reset release to first o_IMemReq: 2 cycles (BOOT, then REQ).
  - Ack to o_InstrValid: 1 cycle.
  - Ready to next o_IMemReq: 1 cycle.

Decomposition:
- Shared package rv_core_pkg holds:
  - FSM state enum (BOOT, REQ, VALID)
  - XLEN=32
  - INSTR_ALIGN_MASK=2'b11
  - PC increment constant 4
- One natural sub-module: next_pc_select, the combinational priority mux and misalign check (trap/redirect/sequential → o_NewPC, misalign flag).
- The FSM and registers stay in fetch_sequencer.

Test Plan:
- Reset release, RESET_VECTOR=32'h0, ack 1 cycle after each request with data 32'h0000_0013, ready tied high → addresses 0,4,8 fetched; o_FetchCount=3 after third accept.
- Ready held low 5 cycles in VALID → o_Instr, o_InstrValid and i_PC stable; no o_IMemReq; accept on cycle 6 → PC=old+4.
- i_Redirect with target 32'h0000_0200 in VALID → PC=32'h200 next edge, o_InstrValid drops, next o_IMemAddr=32'h200, o_FetchCount unchanged.
- i_Redirect target 32'h0000_0300 three cycles before delayed ack → acked data discarded (o_InstrValid stays 0); next o_IMemAddr=32'h300.
- i_Trap and i_Redirect (target 32'h400) in the same cycle → PC=TRAP_VECTOR 32'h100. Separately, redirect to 32'h0000_0402 → PC=32'h100 and o_MisalignErr high exactly one cycle.
- i_Rst asserted while o_IMemReq=1, ack arrives next cycle → ack ignored, all outputs zero, BOOT reloads RESET_VECTOR. PC at 32'hFFFF_FFFC accepted → wraps to 32'h0.
